gate_generator: RTL

Transmit-side companion of the edge-detecting gate synchronizer. Converts single-cycle event pulses in the source clock domain into a gate level that a slower or unrelated destination domain can resynchronize and edge-detect without losing events. Events arriving while a gate is in progress are counted and replayed in order, and a sticky flag marks any that are lost. Sits in the source domain, directly driving the cross-domain wire into the destination's synchronizer.

---
 rtl/gate_generator.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/gate_generator.sv
// Source-domain gate generator: turns event pulses into a resynchronizable gate level.
// Define GATE_GEN_TOGGLE_EN for toggle encoding (one gate inversion per event).
module gate_generator #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             pulse_i,
    output logic             gate_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o
);

    localparam int MAXC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    localparam logic [TW-1:0]    HI_LD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0]    LO_LD = TW'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX  = '1;

`ifdef GATE_GEN_TOGGLE_EN
    typedef enum logic {IDLE, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
`endif

    state_t           state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [CNT_W-1:0] pend_nxt;
    logic             gate_nxt, busy_nxt, ovf_nxt;
    logic             phase_end, last, inc, dec;

    assign phase_end = (timer == '0);
`ifdef GATE_GEN_TOGGLE_EN
    assign last = (state == HOLD) && phase_end;
`else
    assign last = (state == LOW) && phase_end;
`endif
    // A pulse landing on the final cycle with nothing queued starts the next gate directly
    assign dec = last && (pending_o != '0);
    assign inc = pulse_i && (state != IDLE) && !(last && pending_o == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            timer      <= '0;
            gate_o     <= 1'b0;
            busy_o     <= 1'b0;
            pending_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            gate_o     <= gate_nxt;
            busy_o     <= busy_nxt;
            pending_o  <= pend_nxt;
            overflow_o <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
`ifdef GATE_GEN_TOGGLE_EN
        unique case (state)
            IDLE: if (pulse_i) state_nxt = HOLD;
            HOLD: if (last && !(pending_o != '0 || pulse_i)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`else
        unique case (state)
            IDLE: if (pulse_i) state_nxt = HIGH;
            HIGH: if (phase_end) state_nxt = LOW;
            LOW: begin
                if (phase_end)
                    state_nxt = (pending_o != '0 || pulse_i) ? HIGH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`endif
    end

    always_comb begin
        gate_nxt  = gate_o;
        timer_nxt = timer;
        pend_nxt  = pending_o;
        ovf_nxt   = overflow_o;
`ifdef GATE_GEN_TOGGLE_EN
        unique case (state)
            IDLE: begin
                if (pulse_i) begin
                    gate_nxt  = ~gate_o;
                    timer_nxt = HI_LD;
                end
            end
            default: begin
                if (!phase_end) begin
                    timer_nxt = timer - 1'b1;
                end else if (state_nxt == HOLD) begin
                    gate_nxt  = ~gate_o;
                    timer_nxt = HI_LD;
                end
            end
        endcase
`else
        unique case (state)
            IDLE: begin
                if (pulse_i) begin
                    gate_nxt  = 1'b1;
                    timer_nxt = HI_LD;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    gate_nxt  = 1'b0;
                    timer_nxt = LO_LD;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                if (!phase_end) begin
                    timer_nxt = timer - 1'b1;
                end else if (state_nxt == HIGH) begin
                    gate_nxt  = 1'b1;
                    timer_nxt = HI_LD;
                end
            end
        endcase
`endif
        unique case ({inc, dec})
            2'b10: begin
                if (pending_o == CMAX) ovf_nxt = 1'b1;
                else pend_nxt = pending_o + 1'b1;
            end
            2'b01:   pend_nxt = pending_o - 1'b1;
            default: pend_nxt = pending_o;
        endcase
        busy_nxt = (state_nxt != IDLE) || (pend_nxt != '0);
    end

endmodule
